// File: rtl/instruction_sequencer.sv
// Fetch/decode sequencer feeding register_block: two-word fetch, decode, conditional store.
// Optional halt-on-zero-instruction via INSTRUCTION_SEQUENCER_HALT_EN.
module instruction_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic [15:0] flags,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic        pc_advance,
  output logic [15:0] pc_load_value,
  output logic [1:0]  step,
  output logic [3:0]  source,
  output logic [3:0]  dest,
  output logic [15:0] immediate,
  output logic [15:0] offset,
  output logic [3:0]  alu_op,
  output logic [3:0]  to_write,
  output logic        write_enable,
  output logic        push,
  output logic        pop,
  output logic        halted
);

`ifdef INSTRUCTION_SEQUENCER_HALT_EN
  typedef enum logic [2:0] {
    S_FETCH0, S_FETCH1, S_READ, S_WRITE, S_HALTED
  } state_t;
`else
  typedef enum logic [1:0] {
    S_FETCH0, S_FETCH1, S_READ, S_WRITE
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic        w_rd;
  logic [1:0]  w_step;
  logic        w_accept;
  logic        w_cond;
  logic        w_is_halt;
  logic        w_unused;

  logic [15:0] r_word0;
  logic [3:0]  r_alu_op;
  logic [3:0]  r_source;
  logic [3:0]  r_dest;
  logic        r_push_bit;
  logic [2:0]  r_effect;
  logic [7:0]  r_imm;
  logic        r_pop_bit;
  logic [6:0]  r_offset;
  logic        r_cond;

`ifdef INSTRUCTION_SEQUENCER_HALT_EN
  assign w_is_halt = (r_word0 == 16'h0000) && (mem_data == 16'h0000);
`else
  assign w_is_halt = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_step = 2'd0;
    unique case (r_state)
      S_FETCH0: begin
        w_rd   = 1'b1;
        w_step = 2'd0;
        if (mem_ready) w_next = S_FETCH1;
      end
      S_FETCH1: begin
        w_rd   = 1'b1;
        w_step = 2'd1;
`ifdef INSTRUCTION_SEQUENCER_HALT_EN
        if (mem_ready) w_next = w_is_halt ? S_HALTED : S_READ;
`else
        if (mem_ready) w_next = S_READ;
`endif
      end
      S_READ: begin
        w_step = 2'd2;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        w_step = 2'd3;
        w_next = S_FETCH0;
      end
`ifdef INSTRUCTION_SEQUENCER_HALT_EN
      S_HALTED: begin
        w_step = 2'd0;
        w_next = S_HALTED;
      end
`endif
      default: w_next = S_FETCH0;
    endcase
  end

  // Reset kills the request in the same cycle, so a pending fetch is dropped.
  assign mem_read = w_rd & ~reset;
  assign w_accept = mem_read & mem_ready;

  always_comb begin
    w_cond = 1'b0;
    unique case (r_effect)
      3'd0:    w_cond = flags[0];
      3'd1:    w_cond = ~flags[0];
      3'd2:    w_cond = flags[1];
      3'd3:    w_cond = 1'b1;
      3'd5:    w_cond = flags[2];
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_word0    <= 16'h0000;
      r_alu_op   <= 4'd0;
      r_source   <= 4'd0;
      r_dest     <= 4'd0;
      r_push_bit <= 1'b0;
      r_effect   <= 3'd0;
      r_imm      <= 8'd0;
      r_pop_bit  <= 1'b0;
      r_offset   <= 7'd0;
      r_cond     <= 1'b0;
    end else begin
      if (w_accept && r_state == S_FETCH0) r_word0 <= mem_data;
      // Decoded fields only change once the whole instruction is in.
      if (w_accept && r_state == S_FETCH1) begin
        r_alu_op   <= r_word0[15:12];
        r_source   <= r_word0[11:8];
        r_dest     <= r_word0[7:4];
        r_push_bit <= r_word0[3];
        r_effect   <= r_word0[2:0];
        r_imm      <= mem_data[15:8];
        r_pop_bit  <= mem_data[7] & ~r_word0[3];
        r_offset   <= mem_data[6:0];
      end
      if (r_state == S_READ) r_cond <= w_cond;
    end
  end

  assign mem_addr      = pc;
  assign pc_advance    = w_accept;
  assign pc_load_value = RESET_PC;
  assign step          = w_step;
  assign source        = r_source;
  assign dest          = r_dest;
  assign to_write      = r_dest;
  assign alu_op        = r_alu_op;
  assign immediate     = {{8{r_imm[7]}}, r_imm};
  assign offset        = {9'd0, r_offset};
  assign write_enable  = (r_state == S_WRITE) & r_cond & ~reset;
  assign push          = write_enable & r_push_bit;
  assign pop           = write_enable & r_pop_bit;

`ifdef INSTRUCTION_SEQUENCER_HALT_EN
  assign halted = (r_state == S_HALTED) & ~reset;
`else
  assign halted = 1'b0;
`endif

  assign w_unused = ^flags[15:3];

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/decode sequencer that sits directly upstream of `register_block` in grok80. It fetches each 32-bit instruction as two 16-bit words over a ready-handshaked memory port, decodes the fields, and evaluates the store condition against the current flags. It then drives the register block's read and write controls in a fixed four-step sequence, including the PC advance pulses and a `step` count that the register block gates its update on.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, fetch address used after reset; drives `pc_load_value` during reset.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  16  current PC from `register_block`.
- `flags`  in  16  flags from `register_block`: [0] zero, [1] negative, [2] carry.
- `mem_addr`  out  16  fetch address.
- `mem_read`  out  1  fetch request; held until `mem_ready`.
- `mem_ready`  in  1  fetch data valid this cycle.
- `mem_data`  in  16  fetched word.
- `pc_advance`  out  1  one-cycle pulse; `register_block` adds 2 to PC.
- `pc_load_value`  out  16  `RESET_PC` while `reset` is high; otherwise don't-care.
- `step`  out  2  current step: 0 FETCH0, 1 FETCH1, 2 READ, 3 WRITE.
- `source`  out  4  source register select.
- `dest`  out  4  destination register select.
- `immediate`  out  16  sign-extended immediate.
- `offset`  out  16  zero-extended destination offset.
- `alu_op`  out  4  ALU operation code.
- `to_write`  out  4  register to write; equals `dest`.
- `write_enable`  out  1  store strobe.
- `push`  out  1  pre-decrement `to_write`.
- `pop`  out  1  post-increment `to_write`.
- `halted`  out  1  sequencer stopped (HALT_EN only; 0 otherwise).

## Operation
- Word0 fields: [15:12] `alu_op`, [11:8] `source`, [7:4] `dest`, [3] push bit, [2:0] effect.
- Word1 fields: [15:8] immediate (sign-extended to 16 bits), [7] pop bit, [6:0] offset (zero-extended to 16 bits).
- States:
  - FETCH0 (step 0): `mem_addr=pc`, `mem_read=1`. On `mem_ready`, latch word0, pulse `pc_advance`, go to FETCH1.
  - FETCH1 (step 1): `mem_addr=pc`, `mem_read=1`. On `mem_ready`, latch word1, pulse `pc_advance`, go to READ.
  - READ (step 2): decoded outputs stable. Latch `cond = f(effect, flags)`. Go to WRITE.
  - WRITE (step 3): `write_enable = cond`, `push = cond & push_bit`, `pop = cond & pop_bit`. Go to FETCH0.
- Effect codes:
  - 0: zero
  - 1: !zero
  - 2: negative
  - 3: always
  - 4: never
  - 5: carry
  - 6, 7: reserved, behave as never.
- `push` and `pop` both set in word0/word1: `push` wins; `pop` forced to 0.
- Decoded outputs hold their latched values from the end of FETCH1 until the next FETCH1 completes.
- Reset values:
  - `step=0` (FETCH0), `mem_read=0` in the reset cycle.
  - `pc_advance`, `write_enable`, `push`, `pop`, `halted` all 0.
  - All field outputs 0.
  - `mem_addr = pc`.

## Timing
- Minimum 4 cycles per instruction when `mem_ready` is high on the first request cycle.
- Each wait cycle with `mem_ready` low adds one cycle. During a wait: state, `mem_addr` and `mem_read` hold, and `pc_advance` stays 0.
- `pc_advance` occurs exactly once per accepted fetch word, in the accept cycle. The new PC is visible the following cycle.
- `write_enable`, `push` and `pop` each assert for at most one cycle per instruction, and only in WRITE.
- `cond` samples flags in READ. A flags change during WRITE does not affect the current instruction.
- Reset asserted mid-instruction: next cycle is FETCH0 with all strobes 0. A pending fetch is abandoned and no partial write occurs.
- `mem_ready` asserted while `mem_read=0`: ignored.

## Configuration
- `INSTRUCTION_SEQUENCER_HALT_EN` defined:
  - Word0 == 16'h0000 and word1 == 16'h0000 enters HALTED after FETCH1 instead of READ.
  - In HALTED: `halted=1`, `mem_read=0`, no strobes, `step=0`. Only `reset` exits.
- Not defined:
  - All-zero instructions decode normally: `alu_op` 0, effect 0 (store-if-zero), no push/pop.
  - No HALTED state; `halted` tied to 0.

## Test plan
- Reset, `pc=16'h0000`, `mem_ready` always 1, words 16'h1233/16'hFE05 -> `source=2`, `dest=3`, `immediate=16'hFFFE`, `offset=16'h0005`, `alu_op=1`. `write_enable` high only at step 3; two `pc_advance` pulses; 4 cycles total.
- Same instruction with effect 0 and `flags=16'h0000` -> no `write_enable`. Repeat with `flags=16'h0001` -> `write_enable` for one cycle.
- Hold `mem_ready` low 3 cycles in FETCH0 and 2 cycles in FETCH1 -> `mem_addr` stable during each wait, no `pc_advance` during waits, instruction completes in 9 cycles.
- Push bit and pop bit both set, effect 3 -> `push=1`, `pop=0`, `to_write=dest` in WRITE.
- Assert `reset` during FETCH1 after a stall -> next cycle `step=0`, all strobes 0; the next instruction fetch starts cleanly.
- With HALT_EN, fetch 16'h0000/16'h0000 -> `halted=1` and `mem_read=0` persist for 20 cycles. Assert `reset` -> `halted=0`, fetch resumes.
